// File: rtl/timer_irq.sv
// timer_irq: programmable millisecond interrupt generator fed by the free-running ms counter.
// Latency: a change on ms_in becomes a tick one edge later; COUNT and irq update on that tick edge; rd_data is combinational.
// Backpressure: none; a register write is accepted every cycle it is strobed, and irq holds until irq_ack.
//
// Optional feature: define TIMER_IRQ_OVERRUN_EN to build the sticky overrun flag (STATUS bit1, write-1-to-clear).
//
// Ports:
//   clk50mhz, rst_n       - 50 MHz clock, asynchronous active-low reset
//   ms_in                 - free-running millisecond count (wraps at 2^WIDTH)
//   wr_en/wr_addr/wr_data - register write port (0 CTRL, 1 PERIOD, 2 COUNT ro, 3 STATUS)
//   rd_addr/rd_data       - zero-latency register read port
//   irq / irq_ack         - level interrupt (STATUS.pending) and its clearing pulse

module timer_irq #(
  parameter int WIDTH = 16
) (
  input  logic             clk50mhz,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ms_in,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             irq,
  input  logic             irq_ack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic             ctrl_enable;
  logic             ctrl_oneshot;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] ms_prev;
  logic             prev_valid;
  logic             pending;
  logic             overrun;

  logic tick;
  logic ctrl_wr;
  logic period_wr;
  logic expire;

  // prev_valid masks the first cycle after reset so a nonzero ms_in is not
  // mistaken for an increment against the reset value of ms_prev.
  assign tick      = prev_valid && (ms_in != ms_prev);
  assign ctrl_wr   = wr_en && (wr_addr == 2'd0);
  assign period_wr = wr_en && (wr_addr == 2'd1);
  // A CTRL write in the same cycle swallows the tick.
  assign expire    = (state == S_ARMED) && tick && !ctrl_wr && (count == WIDTH'(1));

  assign irq = pending;

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ctrl_enable  <= 1'b0;
      ctrl_oneshot <= 1'b0;
      period       <= '0;
      count        <= '0;
      ms_prev      <= '0;
      prev_valid   <= 1'b0;
      pending      <= 1'b0;
    end else begin
      ms_prev    <= ms_in;
      prev_valid <= 1'b1;

      // PERIOD only lands in COUNT on an arm or a reload, so a write while
      // armed leaves the running count alone.
      if (period_wr) begin
        period <= wr_data;
      end

      if (ctrl_wr) begin
        ctrl_enable  <= wr_data[0];
        ctrl_oneshot <= wr_data[1];
        if (wr_data[0] && (period != '0)) begin
          count <= period;
          state <= S_ARMED;
        end else begin
          state <= S_IDLE;
        end
      end else if ((state == S_ARMED) && tick) begin
        if (count > WIDTH'(1)) begin
          count <= count - WIDTH'(1);
        end else if (ctrl_oneshot) begin
          count <= '0;
          state <= S_DONE;
        end else begin
          count <= period;
          // PERIOD may have been rewritten to 0 while armed; stop rather
          // than sit in ARMED with a zero count.
          if (period == '0) begin
            state <= S_IDLE;
          end
        end
      end

      // An ack coinciding with a new expiry must not lose that expiry.
      if (expire) begin
        pending <= 1'b1;
      end else if (irq_ack) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef TIMER_IRQ_OVERRUN_EN
  logic status_wr;
  assign status_wr = wr_en && (wr_addr == 2'd3);

  // A fresh overrun takes priority over a simultaneous clear.
  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (expire && pending && !irq_ack) begin
      overrun <= 1'b1;
    end else if (status_wr && wr_data[1]) begin
      overrun <= 1'b0;
    end
  end
`else
  assign overrun = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      2'd0:    rd_data = {{(WIDTH-2){1'b0}}, ctrl_oneshot, ctrl_enable};
      2'd1:    rd_data = period;
      2'd2:    rd_data = count;
      default: rd_data = {{(WIDTH-2){1'b0}}, overrun, pending};
    endcase
  end

endmodule

// File: tb/tb_timer_irq.sv
module tb_timer_irq;

  localparam int W = 16;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DONE  = 2;

  logic         clk50mhz = 1'b0;
  logic         rst_n    = 1'b0;
  logic [W-1:0] ms_in    = '0;
  logic         wr_en    = 1'b0;
  logic [1:0]   wr_addr  = 2'd0;
  logic [W-1:0] wr_data  = '0;
  logic [1:0]   rd_addr  = 2'd0;
  logic [W-1:0] rd_data;
  logic         irq;
  logic         irq_ack  = 1'b0;

  timer_irq #(.WIDTH(W)) dut (
    .clk50mhz (clk50mhz),
    .rst_n    (rst_n),
    .ms_in    (ms_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .irq      (irq),
    .irq_ack  (irq_ack)
  );

  always #10 clk50mhz = ~clk50mhz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the register file and interrupt rules.
  bit           m_en, m_os, m_pend, m_ovr, m_pvalid;
  int           m_state;
  logic [W-1:0] m_period, m_count, m_prev;

  task automatic model_reset();
    m_en = 0; m_os = 0; m_pend = 0; m_ovr = 0; m_pvalid = 0;
    m_state = M_IDLE; m_period = '0; m_count = '0; m_prev = '0;
  endtask

  function automatic logic [W-1:0] model_read(input logic [1:0] a);
    logic [W-1:0] v;
    v = '0;
    case (a)
      2'd0: begin v[0] = m_en; v[1] = m_os; end
      2'd1: v = m_period;
      2'd2: v = m_count;
      default: begin v[0] = m_pend; v[1] = m_ovr; end
    endcase
    return v;
  endfunction

  task automatic model_step();
    bit tk, expire;
    tk = m_pvalid && (ms_in != m_prev);
    expire = 0;
    if (wr_en && wr_addr == 2'd0) begin
      m_en = wr_data[0];
      m_os = wr_data[1];
      if (wr_data[0] && m_period != 0) begin
        m_count = m_period;
        m_state = M_ARMED;
      end else begin
        m_state = M_IDLE;
      end
    end else if (m_state == M_ARMED && tk) begin
      if (m_count > 1) begin
        m_count = m_count - 1;
      end else begin
        expire = 1;
        if (m_os) begin
          m_count = 0;
          m_state = M_DONE;
        end else begin
          m_count = m_period;
          if (m_period == 0) m_state = M_IDLE;
        end
      end
    end
    if (wr_en && wr_addr == 2'd3 && wr_data[1]) m_ovr = 0;
`ifdef TIMER_IRQ_OVERRUN_EN
    if (expire && m_pend && !irq_ack) m_ovr = 1;
`endif
    if (expire) m_pend = 1;
    else if (irq_ack) m_pend = 0;
    if (wr_en && wr_addr == 2'd1) m_period = wr_data;
    m_prev = ms_in;
    m_pvalid = 1;
  endtask

  // One clock: model follows the edge, outputs are compared 1 ns later.
  task automatic cycle();
    @(posedge clk50mhz);
    model_step();
    #1;
    wr_en   = 1'b0;
    irq_ack = 1'b0;
    check("irq", W'(irq), W'(m_pend));
    check("rd_data", rd_data, model_read(rd_addr));
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    cycle();
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      ms_in = ms_in + 1'b1;
      cycle();
      for (int g = 0; g < gap; g++) cycle();
    end
  endtask

  // Asserts reset asynchronously, checks reset contents, releases it.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_irq", W'(irq), '0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      check("rst_reg", rd_data, '0);
    end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] st_exp;
    do_reset();
    cycle();

    // Periodic, PERIOD=3, one ms step every 10 cycles.
    rd_addr = 2'd2;
    wr(2'd1, 16'd3);
    wr(2'd0, 16'd1);
    check("per_cnt_load", rd_data, 16'd3);
    ticks(1, 9); check("per_cnt_t1", rd_data, 16'd2);
    ticks(1, 9); check("per_cnt_t2", rd_data, 16'd1);
    check("per_irq_t2", W'(irq), '0);
    ticks(1, 9); check("per_cnt_t3", rd_data, 16'd3);
    check("per_irq_t3", W'(irq), 16'd1);
    ack();
    check("per_irq_ack", W'(irq), '0);
    ticks(2, 9); check("per_irq_t5", W'(irq), '0);
    ticks(1, 9); check("per_irq_t6", W'(irq), 16'd1);

    // One-shot, PERIOD=2.
    ack();
    wr(2'd1, 16'd2);
    wr(2'd0, 16'd3);
    rd_addr = 2'd0; #1; check("os_ctrl", rd_data, 16'd3);
    rd_addr = 2'd2;
    ticks(2, 2);
    check("os_irq", W'(irq), 16'd1);
    check("os_cnt", rd_data, 16'd0);
    ack();
    ticks(3, 2);
    check("os_no_repeat", W'(irq), '0);
    check("os_cnt_hold", rd_data, 16'd0);

    // Wrap and first-cycle suppression.
    ms_in = 16'hFFFF;
    do_reset();
    wr(2'd1, 16'd4);
    wr(2'd0, 16'd1);
    rd_addr = 2'd2; #1;
    check("wrap_load", rd_data, 16'd4);
    ms_in = 16'h0000;
    cycle();
    check("wrap_dec", rd_data, 16'd3);

    // Overrun.
    wr(2'd1, 16'd1);
    wr(2'd0, 16'd1);
    rd_addr = 2'd3;
    ticks(2, 2);
`ifdef TIMER_IRQ_OVERRUN_EN
    st_exp = 16'd3;
`else
    st_exp = 16'd1;
`endif
    check("ovr_status", rd_data, st_exp);
    wr(2'd3, 16'd2);
    check("ovr_clear", rd_data, 16'd1);
    irq_ack = 1'b1;
    ms_in = ms_in + 1'b1;
    cycle();
    check("ovr_ack_expire", rd_data, 16'd1);

    // PERIOD=0 never interrupts.
    ack();
    wr(2'd1, 16'd0);
    wr(2'd0, 16'd1);
    ticks(100, 0);
    check("p0_irq", W'(irq), '0);

    // PERIOD rewrite while armed affects only the next reload.
    wr(2'd1, 16'd4);
    wr(2'd0, 16'd1);
    rd_addr = 2'd2;
    ticks(2, 1);
    check("pw_cnt2", rd_data, 16'd2);
    wr(2'd1, 16'd5);
    check("pw_cnt_kept", rd_data, 16'd2);
    ticks(2, 1);
    check("pw_irq1", W'(irq), 16'd1);
    check("pw_reload", rd_data, 16'd5);
    ack();
    ticks(4, 1);
    check("pw_irq_wait", W'(irq), '0);
    ticks(1, 1);
    check("pw_irq2", W'(irq), 16'd1);

    // Reset with irq asserted.
    check("pre_rst_irq", W'(irq), 16'd1);
    do_reset();

    // Randomized traffic against the model.
    ms_in = 16'hFFF0;
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = (wr_addr == 2'd1) ? W'($urandom_range(0, 5)) : W'($urandom_range(0, 3));
      irq_ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) ms_in = ms_in + W'($urandom_range(1, 3));
      rd_addr = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
# timer_irq

Programmable millisecond interrupt generator that sits directly downstream of the free-running millisecond/second counter block. It consumes the 16-bit millisecond count, detects each increment as a 1 ms tick, and counts down a CPU-programmed period. On expiry it raises a level interrupt to the CPU that is held until acknowledged. It is configured through a small register port on the CPU I/O bus and supports periodic and one-shot modes.

## Interface
- `WIDTH`, default 16: width of the millisecond input, the period, the count and the data bus.
- `clk50mhz` in 1: system clock, 50 MHz; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ms_in` in WIDTH: free-running millisecond count from the timer block; wraps at 2^WIDTH.
- `wr_en` in 1: register write strobe, one cycle per write.
- `wr_addr` in 2: write register select.
- `wr_data` in WIDTH: write data.
- `rd_addr` in 2: read register select.
- `rd_data` out WIDTH: combinational read data.
- `irq` out 1: interrupt request; equals STATUS.pending.
- `irq_ack` in 1: one-cycle pulse that clears pending.

## Operation
- Registers:
  - addr 0, CTRL (rw): bit0 `enable`, bit1 `oneshot`; other bits read 0.
  - addr 1, PERIOD (rw): reload value in ms.
  - addr 2, COUNT (ro): current down-count.
  - addr 3, STATUS: bit0 `pending` (ro); bit1 `overrun` (write 1 to clear).
- Tick detect:
  - `ms_prev` and `prev_valid` are registered.
  - `tick` = `prev_valid & (ms_in != ms_prev)`.
  - Every cycle, `ms_prev` <= `ms_in` and `prev_valid` <= 1.
  - Wrap from 0xFFFF to 0x0000 counts as one tick.
- FSM states:
  - IDLE: disabled.
  - ARMED: counting.
  - DONE: one-shot expired.
- A CTRL write with enable=1 and PERIOD≠0 loads COUNT<=PERIOD and enters ARMED from any state.
  - This also restarts a running count.
  - With PERIOD=0 the state becomes IDLE and no interrupt is ever generated.
- A CTRL write with enable=0 enters IDLE. COUNT is held. pending and overrun are unaffected.
- In ARMED, on each tick:
  - If COUNT>1: COUNT<=COUNT-1.
  - If COUNT==1: expiry. pending<=1.
    - Periodic mode: COUNT<=PERIOD and stay in ARMED.
    - One-shot mode: COUNT<=0 and enter DONE.
- A PERIOD write during ARMED does not change COUNT. The new value takes effect at the next reload.
- Period N produces exactly one expiry every N ticks.
- Overrun: if expiry occurs while pending=1 and no `irq_ack` arrives in the same cycle, overrun<=1 (sticky).
- Simultaneous events:
  - `irq_ack` together with expiry: pending stays 1, overrun is not set.
  - `irq_ack` with pending=0: no effect.
  - A CTRL write and a tick in the same cycle: the write wins and the tick is dropped.
- All arithmetic is unsigned WIDTH-bit. COUNT never underflows.

## Timing
- Reset values:
  - rd_data reflects reset register contents: CTRL=0, PERIOD=0, COUNT=0, STATUS=0.
  - irq=0, state IDLE, prev_valid=0, ms_prev=0.
- The first cycle after reset release generates no tick, regardless of the `ms_in` value.
- A change of `ms_in` at edge k is registered as a tick at edge k+1.
- COUNT and pending update on that same edge, so `irq` rises one cycle after `tick` is high.
- Writes take effect on the edge where `wr_en`=1. A read in the following cycle returns the new value.
- `rd_data` has zero latency: it is a combinational function of `rd_addr` and the registers.
- `irq_ack` clears pending on its edge, so `irq` is low in the next cycle.
- Asserting `rst_n` low mid-count immediately returns all state to reset values, including a pending irq.

## Configuration
- `TIMER_IRQ_OVERRUN_EN` defined:
  - The overrun flag is implemented as described.
  - STATUS bit1 is readable and write-1-to-clear.
- `TIMER_IRQ_OVERRUN_EN` undefined:
  - No overrun register is built.
  - STATUS bit1 reads 0 and writes to it are ignored.
  - All other behaviour is identical.

## Test plan
- Periodic: PERIOD=3, CTRL=0x1, `ms_in` incremented every 10 cycles. Required: `irq` rises 1 cycle after the 3rd tick. After `irq_ack`, `irq` rises again after the 6th tick. COUNT reads 3,2,1,3,…
- One-shot: PERIOD=2, CTRL=0x3, then 5 ticks. Required: exactly one expiry after tick 2, state DONE, COUNT=0. No further pending after ack.
- Wrap and reset: `ms_in` at 0xFFFF after reset, no tick in the first cycle. Then 0xFFFF→0x0000 counts as one tick and decrements COUNT by 1.
- Overrun (macro on): PERIOD=1, no ack for 2 ticks. Required: STATUS=0x3. Writing STATUS=0x2 gives 0x1. Ack and expiry in the same cycle leave STATUS=0x1. With the macro off, STATUS=0x1 in the first step.
- Edge cases:
  - CTRL=0x1 with PERIOD=0: no irq over 100 ticks.
  - PERIOD write of 5 while COUNT=2 with PERIOD=4: next expiry after 2 ticks, the following one after 5.
  - `rst_n` low with irq=1: `irq` goes to 0 immediately and all registers read 0.
